card_dealer_arbiter: RTL and testbench

Sequences the shared card generator between the three blackjack hands (player, split, dealer). It runs the fixed four-card opening deal, then grants single cards to hit/draw requests under a defined priority. Each hand is limited to four cards, matching the four-slot hand registers in the game FSM. The block sits between `card_generation` and the game controller and replaces direct sampling of the generator outputs.

---
 rtl/card_dealer_arbiter.sv | 195 +++++++++++++++++++
 tb/tb_card_dealer_arbiter.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/card_dealer_arbiter.sv
// card_dealer_arbiter
// Shares the card generator between the three blackjack hands. It runs the
// fixed four-card opening deal (player, dealer, player, dealer). After that it
// hands out single cards to hit/draw requests: player and split share a
// round-robin pointer, and the dealer is served only when neither of them is
// eligible. Raw ranks 11..13 are mapped to 10. Invalid raw cards are discarded
// with a bare card_take, and the pending request retries on the next card.
//
// Ports
//   clk, reset                  rising-edge clock, synchronous active-low reset
//   card_in[3:0], card_valid    raw card from the generator
//   card_take                   one-cycle pulse consuming card_in
//   deal_start, round_end       round control pulses
//   split_en                    split hand active (gates req_split)
//   req_player/split/dealer     level requests for one card
//   grant[2:0]                  one-hot {dealer, split, player} pulse
//   card_out[3:0]               mapped card 1..10, valid with grant
//   cnt_player/split/dealer     cards dealt to each hand this round
//   full[2:0]                   {dealer, split, player} hand at MAX_CARDS
//   deal_done                   pulse with the fourth opening grant
//   busy                        block is not IDLE

module card_dealer_arbiter #(
    parameter int MAX_CARDS = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] card_in,
    input  logic       card_valid,
    output logic       card_take,
    input  logic       deal_start,
    input  logic       round_end,
    input  logic       split_en,
    input  logic       req_player,
    input  logic       req_split,
    input  logic       req_dealer,
    output logic [2:0] grant,
    output logic [3:0] card_out,
    output logic [2:0] cnt_player,
    output logic [2:0] cnt_split,
    output logic [2:0] cnt_dealer,
    output logic [2:0] full,
    output logic       deal_done,
    output logic       busy
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DEAL  = 2'd1,
        ST_SERVE = 2'd2
    } state_t;

    localparam logic [2:0] MAX_CNT = 3'(MAX_CARDS);

    state_t     state_q, state_d;
    logic [1:0] step_q, step_d;
    logic       rr_q, rr_d;
    logic [2:0] cnt_player_q, cnt_player_d;
    logic [2:0] cnt_split_q, cnt_split_d;
    logic [2:0] cnt_dealer_q, cnt_dealer_d;
    logic [2:0] grant_q, grant_d;
    logic [3:0] card_out_q, card_out_d;
    logic       card_take_q, card_take_d;
    logic       deal_done_q, deal_done_d;

    logic       raw_ok;
    logic [3:0] mapped;
    logic       elig_p, elig_s, elig_d;
    logic [2:0] pick;
    logic       accept;
    logic       hit;
    logic       last_deal;

    assign full[0] = (cnt_player_q == MAX_CNT);
    assign full[1] = (cnt_split_q == MAX_CNT);
    assign full[2] = (cnt_dealer_q == MAX_CNT);

    assign raw_ok = (card_in >= 4'd1) && (card_in <= 4'd13);
    assign mapped = (card_in > 4'd10) ? 4'd10 : card_in;

    assign elig_p = req_player && !full[0];
    assign elig_s = req_split && split_en && !full[1];
    assign elig_d = req_dealer && !full[2];

    // Hand that would take the current card. The deal order alternates
    // player/dealer on the step LSB; rr_q=0 favours player on a tie.
    always_comb begin
        pick = 3'b000;
        case (state_q)
            ST_DEAL:  pick = step_q[0] ? 3'b100 : 3'b001;
            ST_SERVE: begin
                if (elig_p && elig_s)
                    pick = rr_q ? 3'b010 : 3'b001;
                else if (elig_p)
                    pick = 3'b001;
                else if (elig_s)
                    pick = 3'b010;
                else if (elig_d)
                    pick = 3'b100;
            end
            default:  pick = 3'b000;
        endcase
        if (round_end)
            pick = 3'b000;
    end

    // A pending pick plus a card consumes it. Only a valid raw card is granted.
    assign accept    = card_valid && (pick != 3'b000);
    assign hit       = accept && raw_ok;
    assign last_deal = (state_q == ST_DEAL) && hit && (step_q == 2'd3);

    always_ff @(posedge clk) begin
        if (!reset)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (round_end) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:  if (deal_start) state_d = ST_DEAL;
                ST_DEAL:  if (last_deal) state_d = ST_SERVE;
                ST_SERVE: state_d = ST_SERVE;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    // Next values of the registered pulses, counters, deal step and RR pointer.
    always_comb begin
        grant_d      = hit ? pick : 3'b000;
        card_out_d   = hit ? mapped : 4'd0;
        card_take_d  = accept;
        deal_done_d  = last_deal;
        cnt_player_d = cnt_player_q;
        cnt_split_d  = cnt_split_q;
        cnt_dealer_d = cnt_dealer_q;
        step_d       = step_q;
        rr_d         = rr_q;

        if (round_end) begin
            cnt_player_d = 3'd0;
            cnt_split_d  = 3'd0;
            cnt_dealer_d = 3'd0;
            step_d       = 2'd0;
            rr_d         = 1'b0;
        end else if (hit) begin
            if (pick[0] && !full[0]) cnt_player_d = cnt_player_q + 3'd1;
            if (pick[1] && !full[1]) cnt_split_d  = cnt_split_q + 3'd1;
            if (pick[2] && !full[2]) cnt_dealer_d = cnt_dealer_q + 3'd1;
            if (state_q == ST_DEAL)
                step_d = step_q + 2'd1;
            if ((state_q == ST_SERVE) && (pick[0] || pick[1]))
                rr_d = ~rr_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            step_q       <= 2'd0;
            rr_q         <= 1'b0;
            cnt_player_q <= 3'd0;
            cnt_split_q  <= 3'd0;
            cnt_dealer_q <= 3'd0;
            grant_q      <= 3'b000;
            card_out_q   <= 4'd0;
            card_take_q  <= 1'b0;
            deal_done_q  <= 1'b0;
        end else begin
            step_q       <= step_d;
            rr_q         <= rr_d;
            cnt_player_q <= cnt_player_d;
            cnt_split_q  <= cnt_split_d;
            cnt_dealer_q <= cnt_dealer_d;
            grant_q      <= grant_d;
            card_out_q   <= card_out_d;
            card_take_q  <= card_take_d;
            deal_done_q  <= deal_done_d;
        end
    end

    assign grant      = grant_q;
    assign card_out   = card_out_q;
    assign card_take  = card_take_q;
    assign deal_done  = deal_done_q;
    assign cnt_player = cnt_player_q;
    assign cnt_split  = cnt_split_q;
    assign cnt_dealer = cnt_dealer_q;
    assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_card_dealer_arbiter.sv
// tb_card_dealer_arbiter
// Directed walk through the opening deal, round-robin, dealer priority, the
// full-hand limit, invalid-card discard and round_end override. This is
// followed by a randomized phase. Every cycle is compared against a
// hand-level model that tracks the phase, the per-hand counts and whose turn
// it is.

module tb_card_dealer_arbiter;

    localparam int MAX = 4;

    logic       clk;
    logic       reset;
    logic [3:0] card_in;
    logic       card_valid;
    logic       card_take;
    logic       deal_start;
    logic       round_end;
    logic       split_en;
    logic       req_player;
    logic       req_split;
    logic       req_dealer;
    logic [2:0] grant;
    logic [3:0] card_out;
    logic [2:0] cnt_player;
    logic [2:0] cnt_split;
    logic [2:0] cnt_dealer;
    logic [2:0] full;
    logic       deal_done;
    logic       busy;

    int compared   = 0;
    int mismatched = 0;

    // Model state: phase 0=idle 1=opening deal 2=serving.
    // Hands 0=player 1=split 2=dealer.
    int m_phase;
    int m_cnt[3];
    int m_dealt;
    int m_turn;
    int deal_order[4] = '{0, 2, 0, 2};

    logic [2:0] e_grant;
    logic [3:0] e_card_out;
    logic       e_take;
    logic       e_done;

    card_dealer_arbiter #(.MAX_CARDS(MAX)) dut (
        .clk        (clk),
        .reset      (reset),
        .card_in    (card_in),
        .card_valid (card_valid),
        .card_take  (card_take),
        .deal_start (deal_start),
        .round_end  (round_end),
        .split_en   (split_en),
        .req_player (req_player),
        .req_split  (req_split),
        .req_dealer (req_dealer),
        .grant      (grant),
        .card_out   (card_out),
        .cnt_player (cnt_player),
        .cnt_split  (cnt_split),
        .cnt_dealer (cnt_dealer),
        .full       (full),
        .deal_done  (deal_done),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Predicts what the coming clock edge does, from the inputs now driven.
    task automatic modelEdge();
        int  hand;
        bit  elig[3];
        e_grant    = 3'b000;
        e_card_out = 4'd0;
        e_take     = 1'b0;
        e_done     = 1'b0;
        if (!reset || round_end) begin
            m_phase = 0;
            m_cnt   = '{0, 0, 0};
            m_dealt = 0;
            m_turn  = 0;
            return;
        end
        if (m_phase == 0) begin
            if (deal_start) m_phase = 1;
            return;
        end
        hand = -1;
        if (m_phase == 1) begin
            hand = deal_order[m_dealt];
        end else begin
            elig[0] = req_player && (m_cnt[0] < MAX);
            elig[1] = req_split && split_en && (m_cnt[1] < MAX);
            elig[2] = req_dealer && (m_cnt[2] < MAX);
            if (elig[0] && elig[1]) hand = m_turn;
            else if (elig[0])       hand = 0;
            else if (elig[1])       hand = 1;
            else if (elig[2])       hand = 2;
        end
        if (hand < 0 || !card_valid) return;
        e_take = 1'b1;
        if (card_in < 1 || card_in > 13) return;
        e_grant    = 3'(1 << hand);
        e_card_out = (card_in > 10) ? 4'd10 : card_in;
        if (m_cnt[hand] < MAX) m_cnt[hand] = m_cnt[hand] + 1;
        if (m_phase == 1) begin
            m_dealt = m_dealt + 1;
            if (m_dealt == 4) begin
                e_done  = 1'b1;
                m_phase = 2;
                m_dealt = 0;
            end
        end else if (hand != 2) begin
            m_turn = 1 - m_turn;
        end
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        compared++;
        assert (obs === exp_v) else begin
            mismatched++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    task automatic checkOutput();
        logic [2:0] e_full;
        e_full = {m_cnt[2] == MAX, m_cnt[1] == MAX, m_cnt[0] == MAX};
        check("grant",      8'(grant),      8'(e_grant));
        check("card_out",   8'(card_out),   8'(e_card_out));
        check("card_take",  8'(card_take),  8'(e_take));
        check("cnt_player", 8'(cnt_player), 8'(m_cnt[0]));
        check("cnt_split",  8'(cnt_split),  8'(m_cnt[1]));
        check("cnt_dealer", 8'(cnt_dealer), 8'(m_cnt[2]));
        check("full",       8'(full),       8'(e_full));
        check("deal_done",  8'(deal_done),  8'(e_done));
        check("busy",       8'(busy),       8'(m_phase != 0));
    endtask

    task automatic applyStimulus(input logic rst, input logic [3:0] cin, input logic cv,
                                 input logic ds, input logic re, input logic se,
                                 input logic rp, input logic rs, input logic rd);
        reset      = rst;
        card_in    = cin;
        card_valid = cv;
        deal_start = ds;
        round_end  = re;
        split_en   = se;
        req_player = rp;
        req_split  = rs;
        req_dealer = rd;
        modelEdge();
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    task automatic runDeal(input logic [3:0] c0, input logic [3:0] c1,
                           input logic [3:0] c2, input logic [3:0] c3);
        applyStimulus(1, c0, 1, 1, 0, 0, 0, 0, 0);
        applyStimulus(1, c0, 1, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, c1, 1, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, c2, 1, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, c3, 1, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        m_phase = 0;
        m_cnt   = '{0, 0, 0};
        m_dealt = 0;
        m_turn  = 0;

        // Reset for two cycles.
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        check("reset_busy", 8'(busy), 8'd0);

        // Opening deal 5,12,1,9.
        runDeal(4'd5, 4'd12, 4'd1, 4'd9);
        check("deal_last_grant", 8'(grant), 8'b100);
        check("deal_last_card", 8'(card_out), 8'd9);
        check("deal_done_pulse", 8'(deal_done), 8'd1);
        check("deal_cnt_player", 8'(cnt_player), 8'd2);
        check("deal_cnt_split", 8'(cnt_split), 8'd0);
        check("deal_cnt_dealer", 8'(cnt_dealer), 8'd2);

        // Player and dealer together: player first, then dealer.
        applyStimulus(1, 3, 1, 0, 0, 0, 1, 0, 1);
        check("prio_player_first", 8'(grant), 8'b001);
        applyStimulus(1, 8, 1, 0, 0, 0, 0, 0, 1);
        check("prio_dealer_next", 8'(grant), 8'b100);
        applyStimulus(1, 8, 1, 0, 0, 0, 0, 0, 0);

        // New round; player and split held together alternate P,S,P,S.
        applyStimulus(1, 8, 1, 0, 1, 0, 0, 0, 0);
        runDeal(4'd2, 4'd3, 4'd4, 4'd5);
        applyStimulus(1, 6, 1, 0, 0, 1, 1, 1, 0);
        check("rr_1", 8'(grant), 8'b001);
        applyStimulus(1, 7, 1, 0, 0, 1, 1, 1, 0);
        check("rr_2", 8'(grant), 8'b010);
        applyStimulus(1, 8, 1, 0, 0, 1, 1, 1, 0);
        check("rr_3", 8'(grant), 8'b001);
        applyStimulus(1, 9, 1, 0, 0, 1, 1, 1, 0);
        check("rr_4", 8'(grant), 8'b010);

        // Player is full: the held request is dropped.
        applyStimulus(1, 10, 1, 0, 0, 1, 1, 0, 0);
        applyStimulus(1, 10, 1, 0, 0, 1, 1, 0, 0);
        check("full_no_take", 8'(card_take), 8'd0);
        check("full_cnt", 8'(cnt_player), 8'd4);
        check("full_flag", 8'(full), 8'b001);

        // Invalid cards 0 and 14 are discarded, then 7 is granted.
        applyStimulus(1, 10, 1, 0, 1, 0, 0, 0, 0);
        runDeal(4'd1, 4'd1, 4'd1, 4'd1);
        applyStimulus(1, 0, 1, 0, 0, 0, 1, 0, 0);
        check("inv0_take", 8'(card_take), 8'd1);
        applyStimulus(1, 14, 1, 0, 0, 0, 1, 0, 0);
        check("inv14_grant", 8'(grant), 8'd0);
        applyStimulus(1, 7, 1, 0, 0, 0, 1, 0, 0);
        check("retry_grant", 8'(grant), 8'b001);
        check("retry_card", 8'(card_out), 8'd7);

        // round_end with a pending grant wins.
        applyStimulus(1, 6, 1, 0, 1, 0, 1, 0, 0);
        check("re_no_grant", 8'(grant), 8'd0);
        check("re_no_take", 8'(card_take), 8'd0);
        check("re_cnt", 8'(cnt_player), 8'd0);
        check("re_idle", 8'(busy), 8'd0);

        // split_en low: split requests never granted.
        runDeal(4'd2, 4'd2, 4'd2, 4'd2);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 4, 1, 0, 0, 0, 0, 1, 0);
            check("split_disabled", 8'(grant), 8'd0);
        end

        // Randomized phase.
        for (int i = 0; i < 600; i++) begin
            applyStimulus(($urandom_range(0, 99) != 0),
                          4'($urandom_range(0, 15)),
                          ($urandom_range(0, 3) != 0),
                          ($urandom_range(0, 5) == 0),
                          ($urandom_range(0, 24) == 0),
                          1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
